srl_fifo_mc: RTL and testbench

Multi-channel shift-register FIFO bank: CHANNELS independent FIFOs, each DATA_WIDTH × DEPTH, built on SRL-style storage. Shifts in on push and reads at address count-1. Adds a valid/ready handshake, per-channel occupancy, an almost-full flag and a synchronous flush. It sits between HLS dataflow processes in the Linear_Layer datapath, for example PE start tokens and packed i4×i4 operand streams. It replaces per-channel start FIFOs with one parametrised block.

---
 rtl/srl_fifo_mc.sv | 67 ++++++
 tb/tb_srl_fifo_mc.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/srl_fifo_mc.sv
// srl_fifo_mc: bank of independent SRL-style FIFOs with valid/ready, occupancy, almost-full and flush
module srl_fifo_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CHANNELS   = 4,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                                  ap_clk,
  input  logic                                  ap_rst_n,
  input  logic                                  flush,
  input  logic [CHANNELS-1:0]                   s_valid,
  output logic [CHANNELS-1:0]                   s_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]        s_data,
  output logic [CHANNELS-1:0]                   m_valid,
  input  logic [CHANNELS-1:0]                   m_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0]        m_data,
  output logic [CHANNELS*(ADDR_WIDTH+1)-1:0]    count,
  output logic [CHANNELS-1:0]                   almost_full
);
  localparam int CW = ADDR_WIDTH + 1;

  logic init_done_q, init_done_d;

  // init_done only ever rises; it keeps s_ready low until the first edge after reset release
  always_comb init_done_d = 1'b1;

  // init_done register, cleared asynchronously
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) init_done_q <= 1'b0;
    else           init_done_q <= init_done_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] srl_q [DEPTH];
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  full, empty, push, pop;

    // handshake qualification and next occupancy; flush wins over push and pop
    always_comb begin
      full  = cnt_q == CW'(DEPTH);
      empty = cnt_q == '0;
      push  = s_valid[c] & init_done_q & ~full & ~flush;
      pop   = m_ready[c] & ~empty & ~flush;
      addr  = empty ? '0 : ADDR_WIDTH'(cnt_q - 1'b1);
      cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    // occupancy register, cleared asynchronously
    always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) cnt_q <= '0;
      else           cnt_q <= cnt_d;

    // shift register storage, no reset so it maps onto SRL primitives
    always_ff @(posedge ap_clk)
      if (push) begin
        srl_q[0] <= s_data[c*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i < DEPTH; i++) srl_q[i] <= srl_q[i-1];
      end

    assign s_ready[c]                           = init_done_q & ~full;
    assign m_valid[c]                           = ~empty;
    assign m_data[c*DATA_WIDTH +: DATA_WIDTH]   = srl_q[addr];
    assign count[c*CW +: CW]                    = cnt_q;
    assign almost_full[c]                       = cnt_q >= CW'(AF_LEVEL);
  end
endmodule

// File: tb/tb_srl_fifo_mc.sv
// tb_srl_fifo_mc: directed and random scoreboard bench for srl_fifo_mc
module tb_srl_fifo_mc;
  localparam int W = 8, D = 16, C = 4, AW = $clog2(D), CW = AW + 1;

  logic            ap_clk = 1'b0, ap_rst_n = 1'b0, flush = 1'b0;
  logic [C-1:0]    s_valid = '0, m_ready = '0, s_ready, m_valid, almost_full;
  logic [C*W-1:0]  s_data = '0, m_data;
  logic [C*CW-1:0] count;
  int              checks = 0, errors = 0;
  logic [W-1:0]    mq [C][$];
  logic            init_m = 1'b0;

  srl_fifo_mc #(.DATA_WIDTH(W), .DEPTH(D), .CHANNELS(C)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .almost_full(almost_full)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic check_state();
    for (int c = 0; c < C; c++) begin
      check($sformatf("count[%0d]", c), 32'(count[c*CW +: CW]), 32'(mq[c].size()));
      check($sformatf("m_valid[%0d]", c), 32'(m_valid[c]), 32'(mq[c].size() != 0));
      check($sformatf("s_ready[%0d]", c), 32'(s_ready[c]), 32'(init_m && mq[c].size() < D));
      check($sformatf("almost_full[%0d]", c), 32'(almost_full[c]), 32'(mq[c].size() >= D - 2));
    end
  endtask

  // one clock: compare popped heads against the scoreboard, advance the model, check outputs
  task automatic cycle();
    logic [C-1:0] pu, po;
    for (int c = 0; c < C; c++) begin
      pu[c] = s_valid[c] && init_m && mq[c].size() < D && !flush;
      po[c] = m_ready[c] && mq[c].size() != 0 && !flush;
      if (po[c]) check($sformatf("m_data[%0d]", c), 32'(m_data[c*W +: W]), 32'(mq[c][0]));
    end
    @(posedge ap_clk);
    for (int c = 0; c < C; c++)
      if (flush) mq[c].delete();
      else begin
        if (po[c]) void'(mq[c].pop_front());
        if (pu[c]) mq[c].push_back(s_data[c*W +: W]);
      end
    if (ap_rst_n) init_m = 1'b1;
    #1;
    check_state();
  endtask

  initial begin
    // reset held for 5 cycles, released between edges
    for (int i = 0; i < 5; i++) cycle();
    check("s_ready_in_reset", 32'(s_ready), 32'(0));
    ap_rst_n = 1'b1;
    #1;
    check("s_ready_after_release", 32'(s_ready), 32'(0));
    cycle();
    check("s_ready_init", 32'(s_ready), 32'(4'hF));

    // fill channel 0 with 17 pushes, the last is refused
    for (int i = 1; i <= 17; i++) begin
      s_valid = 4'b0001;
      s_data[7:0] = 8'(i);
      cycle();
      if (i == 14) check("af_at_14", 32'(almost_full[0]), 32'(1));
      if (i == 13) check("af_at_13", 32'(almost_full[0]), 32'(0));
    end
    check("count_full", 32'(count[CW-1:0]), 32'(16));
    check("s_ready_full", 32'(s_ready[0]), 32'(0));
    s_valid = '0;
    m_ready = 4'b0001;
    for (int i = 0; i < 16; i++) cycle();
    check("m_valid_drained", 32'(m_valid[0]), 32'(0));
    m_ready = '0;

    // occupancy 5 then sustained push+pop for 20 cycles
    s_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin s_data[7:0] = 8'(8'h20 + i); cycle(); end
    m_ready = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      s_data[7:0] = 8'(8'h40 + i);
      cycle();
      check("count_steady", 32'(count[CW-1:0]), 32'(5));
    end
    m_ready = '0;
    for (int i = 0; i < 20 && mq[0].size() < D; i++) begin s_data[7:0] = 8'(8'h80 + i); cycle(); end
    check("count_refill", 32'(count[CW-1:0]), 32'(16));
    m_ready = 4'b0001;
    s_data[7:0] = 8'hEE;
    cycle();
    check("full_push_pop", 32'(count[CW-1:0]), 32'(15));
    s_valid = '0;
    for (int i = 0; i < 20 && mq[0].size() != 0; i++) cycle();
    m_ready = '0;

    // all channels to 7, then flush with push and pop asserted
    s_valid = 4'hF;
    for (int i = 0; i < 7; i++) begin s_data = {$urandom}; cycle(); end
    check("count7_ch3", 32'(count[3*CW +: CW]), 32'(7));
    flush = 1'b1;
    m_ready = 4'hF;
    cycle();
    check("flush_m_valid", 32'(m_valid), 32'(0));
    flush = 1'b0;
    m_ready = '0;
    s_valid = 4'b0001;
    s_data[7:0] = 8'hAB;
    cycle();
    check("after_flush_data", 32'(m_data[7:0]), 32'(8'hAB));
    s_valid = '0;
    m_ready = 4'b0001;
    cycle();

    // random traffic on every channel
    for (int i = 0; i < 10000; i++) begin
      s_valid = 4'($urandom);
      m_ready = 4'($urandom);
      s_data  = {$urandom};
      cycle();
    end

    // drain, refill channel 1 to 9, then reset between edges
    s_valid = '0;
    m_ready = 4'hF;
    for (int i = 0; i < 20; i++) cycle();
    m_ready = '0;
    s_valid = 4'b0010;
    for (int i = 0; i < 9; i++) begin s_data[15:8] = 8'(i + 1); cycle(); end
    check("count9_ch1", 32'(count[CW +: CW]), 32'(9));
    #3 ap_rst_n = 1'b0;
    #1;
    check("async_count", 32'(count[CW +: CW]), 32'(0));
    check("async_m_valid", 32'(m_valid), 32'(0));
    check("async_s_ready", 32'(s_ready), 32'(0));
    for (int c = 0; c < C; c++) mq[c].delete();
    init_m = 1'b0;
    s_valid = '0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
